// File: rtl/debug_slave_pkg.sv
// Shared definitions for the CPU debug slave: default widths, instruction
// codes and the packed command record carried through the command queue.
package debug_slave_pkg;

  localparam int SR_W_DEF    = 38;
  localparam int IR_W_DEF    = 2;
  localparam int ACT_BIT_DEF = 34;
  localparam int NUM_CMD     = 2 ** IR_W_DEF;

  typedef enum logic [IR_W_DEF-1:0] {
    IR_OCIMEM    = 2'd0,
    IR_TRACEMEM  = 2'd1,
    IR_BREAK     = 2'd2,
    IR_TRACECTRL = 2'd3
  } ir_code_e;

  typedef struct packed {
    logic [IR_W_DEF-1:0] ir;
    logic [SR_W_DEF-1:0] sr;
  } cmd_t;

endpackage

// File: rtl/debug_slave_cmd_queue_if.sv
// Command release channel between the queue (master) and the CPU debug
// logic (slave): valid/ready handshake plus the decoded action pulses.
interface debug_slave_cmd_queue_if
  import debug_slave_pkg::*;
#(
  parameter int SR_W = SR_W_DEF,
  parameter int IR_W = IR_W_DEF
) ();

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [IR_W-1:0]      cmd_ir;
  logic [SR_W-1:0]      jdo;
  logic [2**IR_W-1:0]   take_action;
  logic [2**IR_W-1:0]   take_no_action;

  modport master (
    output cmd_valid, cmd_ir, jdo, take_action, take_no_action,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_ir, jdo, take_action, take_no_action,
    output cmd_ready
  );

endinterface

// File: rtl/debug_slave_sync.sv
// Multi-flop synchroniser for a single asynchronous strobe.
module debug_slave_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage_q;
  logic [STAGES-1:0] stage_d;

  // shift the raw strobe in at the bottom of the chain
  always_comb begin
    stage_d = {stage_q[STAGES-2:0], d};
  end

  // synchroniser flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage_q <= '0;
    else        stage_q <= stage_d;
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/debug_slave_cmd_queue.sv
// Captures virtual-JTAG data-register updates into a command FIFO and
// releases them to the CPU debug logic with one-hot action pulses.
module debug_slave_cmd_queue
  import debug_slave_pkg::*;
#(
  parameter int SR_W        = SR_W_DEF,
  parameter int IR_W        = IR_W_DEF,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ACT_BIT     = ACT_BIT_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       vs_udr,
  input  logic                       vs_uir,
  input  logic [IR_W-1:0]            ir_in,
  input  logic [SR_W-1:0]            sr,
  output logic                       ir_update,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       ovf_sticky,
  input  logic                       ovf_clr,
  debug_slave_cmd_queue_if.master    cmd_if
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = $clog2(DEPTH+1);
  localparam int CW    = IR_W + SR_W;
  localparam int N_CMD = 2 ** IR_W;

  logic udr_sync;
  logic uir_sync;

  debug_slave_sync #(.STAGES(SYNC_STAGES)) u_sync_udr (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (vs_udr),
    .q     (udr_sync)
  );

  debug_slave_sync #(.STAGES(SYNC_STAGES)) u_sync_uir (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (vs_uir),
    .q     (uir_sync)
  );

  // Synchroniser outputs are reset zeros, not real samples, until the chain
  // has filled. The arm flops only accept a low level once it is real, so a
  // strobe held high across reset never looks like a fresh rise.
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic udr_prev_q, udr_prev_d, udr_arm_q, udr_arm_d, udr_evt_q, udr_evt_d;
  logic uir_prev_q, uir_prev_d, uir_arm_q, uir_arm_d, uir_evt_q, uir_evt_d;
  logic sync_ok;

  logic [AW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      mem_q [DEPTH];
  logic [LW-1:0]      level_w;
  logic               full, empty, pop, push, ovf_set;
  logic [CW-1:0]      head;
  logic [IR_W-1:0]    head_ir;
  logic [SR_W-1:0]    head_sr;
  logic [SR_W-1:0]    jdo_q, jdo_d;
  logic [N_CMD-1:0]   ta_q, ta_d, tna_q, tna_d;
  logic               ovf_q, ovf_d;

  assign sync_ok = fill_q[SYNC_STAGES-1];

  // rising-edge detection on both synchronised strobes, registered pulses
  always_comb begin
    fill_d     = {fill_q[SYNC_STAGES-2:0], 1'b1};
    udr_prev_d = udr_sync;
    udr_arm_d  = udr_arm_q | (sync_ok & ~udr_sync);
    udr_evt_d  = udr_sync & ~udr_prev_q & udr_arm_q;
    uir_prev_d = uir_sync;
    uir_arm_d  = uir_arm_q | (sync_ok & ~uir_sync);
    uir_evt_d  = uir_sync & ~uir_prev_q & uir_arm_q;
  end

  // occupancy comes from the extra pointer MSB, so full and empty differ
  assign level_w = LW'(wr_ptr_q - rd_ptr_q);
  assign full    = (level_w == LW'(DEPTH));
  assign empty   = (level_w == '0);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign head_ir = head[CW-1:SR_W];
  assign head_sr = head[SR_W-1:0];

  // push/pop arbitration, overflow flag and pop decode
  always_comb begin
    pop      = ~empty & cmd_if.cmd_ready;
    push     = udr_evt_q & (~full | pop);
    ovf_set  = udr_evt_q & full & ~pop;
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    ovf_d    = ovf_set | (ovf_q & ~ovf_clr);
    jdo_d    = jdo_q;
    ta_d     = '0;
    tna_d    = '0;
    if (pop) begin
      jdo_d = head_sr;
      if (head_sr[ACT_BIT]) ta_d[head_ir]  = 1'b1;
      else                  tna_d[head_ir] = 1'b1;
    end
  end

  // control and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_q     <= '0;
      udr_prev_q <= 1'b0;
      udr_arm_q  <= 1'b0;
      udr_evt_q  <= 1'b0;
      uir_prev_q <= 1'b0;
      uir_arm_q  <= 1'b0;
      uir_evt_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      jdo_q      <= '0;
      ta_q       <= '0;
      tna_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      fill_q     <= fill_d;
      udr_prev_q <= udr_prev_d;
      udr_arm_q  <= udr_arm_d;
      udr_evt_q  <= udr_evt_d;
      uir_prev_q <= uir_prev_d;
      uir_arm_q  <= uir_arm_d;
      uir_evt_q  <= uir_evt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      jdo_q      <= jdo_d;
      ta_q       <= ta_d;
      tna_q      <= tna_d;
      ovf_q      <= ovf_d;
    end
  end

  // command storage; ir_in/sr are still stable when the push lands
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {ir_in, sr};
    end
  end

  assign cmd_if.cmd_valid      = ~empty;
  assign cmd_if.cmd_ir         = empty ? '0 : head_ir;
  assign cmd_if.jdo            = jdo_q;
  assign cmd_if.take_action    = ta_q;
  assign cmd_if.take_no_action = tna_q;
  assign ir_update             = uir_evt_q;
  assign level                 = level_w;
  assign ovf_sticky            = ovf_q;

endmodule

// File: tb/tb_debug_slave_cmd_queue.sv
module tb_debug_slave_cmd_queue;
  import debug_slave_pkg::*;

  localparam int SR_W  = 38;
  localparam int IR_W  = 2;
  localparam int DEPTH = 4;
  localparam int SYNCS = 2;
  localparam int ACTB  = 34;
  localparam int N_CMD = 4;
  localparam int LW    = 3;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            vs_udr = 1'b0;
  logic            vs_uir = 1'b0;
  logic [IR_W-1:0] ir_in = '0;
  logic [SR_W-1:0] sr = '0;
  logic            ir_update;
  logic [LW-1:0]   level;
  logic            ovf_sticky;
  logic            ovf_clr = 1'b0;

  debug_slave_cmd_queue_if #(.SR_W(SR_W), .IR_W(IR_W)) cmd_if ();

  debug_slave_cmd_queue #(
    .SR_W(SR_W), .IR_W(IR_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNCS), .ACT_BIT(ACTB)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .vs_udr     (vs_udr),
    .vs_uir     (vs_uir),
    .ir_in      (ir_in),
    .sr         (sr),
    .ir_update  (ir_update),
    .level      (level),
    .ovf_sticky (ovf_sticky),
    .ovf_clr    (ovf_clr),
    .cmd_if     (cmd_if.master)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  int   uir_pulses = 0;
  cmd_t model[$];
  bit   ovf_model = 1'b0;

  always @(negedge clk) if (ir_update === 1'b1) uir_pulses++;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200us");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SR_W-1:0] rand_sr(input bit act);
    logic [63:0]     r;
    logic [SR_W-1:0] s;
    r = {$urandom, $urandom};
    s = r[SR_W-1:0];
    s[ACTB] = act;
    return s;
  endfunction

  function automatic logic [N_CMD-1:0] exp_pulse(input logic [IR_W-1:0] ir, input bit hit);
    return hit ? (N_CMD'(1) << ir) : '0;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, cmd_if.cmd_valid, 0);
    chk({tag, "_ir"}, cmd_if.cmd_ir, 0);
    chk({tag, "_jdo"}, cmd_if.jdo, 0);
    chk({tag, "_ta"}, cmd_if.take_action, 0);
    chk({tag, "_tna"}, cmd_if.take_no_action, 0);
    chk({tag, "_iru"}, ir_update, 0);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_ovf"}, ovf_sticky, 0);
  endtask

  // One udr strobe; the push lands on the 4th edge after the rise. Optionally
  // a pop and/or ovf_clr is presented on exactly that edge.
  task automatic udr_event(input string tag, input logic [IR_W-1:0] ir,
                           input logic [SR_W-1:0] s, input bit pop_at_push,
                           input bit clr_at_push);
    cmd_t e, popped;
    bit   popping, set;
    ir_in = ir; sr = s; vs_udr = 1'b1;
    tick(); tick();
    vs_udr = 1'b0;
    tick();
    chk({tag, "_prepush_level"}, level, model.size());
    if (pop_at_push) cmd_if.cmd_ready = 1'b1;
    if (clr_at_push) ovf_clr = 1'b1;
    popping = pop_at_push && (model.size() > 0);
    if (popping) popped = model[0];
    tick();
    cmd_if.cmd_ready = 1'b0;
    ovf_clr = 1'b0;
    e.ir = ir; e.sr = s;
    set = 1'b0;
    if (popping) void'(model.pop_front());
    if (model.size() < DEPTH) model.push_back(e);
    else set = 1'b1;
    ovf_model = set ? 1'b1 : (clr_at_push ? 1'b0 : ovf_model);
    chk({tag, "_level"}, level, model.size());
    chk({tag, "_valid"}, cmd_if.cmd_valid, model.size() != 0);
    chk({tag, "_ovf"}, ovf_sticky, ovf_model);
    if (popping) begin
      chk({tag, "_pp_ta"}, cmd_if.take_action, exp_pulse(popped.ir, popped.sr[ACTB]));
      chk({tag, "_pp_tna"}, cmd_if.take_no_action, exp_pulse(popped.ir, !popped.sr[ACTB]));
      chk({tag, "_pp_jdo"}, cmd_if.jdo, popped.sr);
    end
  endtask

  task automatic pop_check(input string tag);
    cmd_t e;
    if (model.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed empty model, expected queued entry", tag);
      return;
    end
    e = model.pop_front();
    chk({tag, "_valid"}, cmd_if.cmd_valid, 1);
    chk({tag, "_cmd_ir"}, cmd_if.cmd_ir, e.ir);
    cmd_if.cmd_ready = 1'b1;
    tick();
    cmd_if.cmd_ready = 1'b0;
    chk({tag, "_ta"}, cmd_if.take_action, exp_pulse(e.ir, e.sr[ACTB]));
    chk({tag, "_tna"}, cmd_if.take_no_action, exp_pulse(e.ir, !e.sr[ACTB]));
    chk({tag, "_jdo"}, cmd_if.jdo, e.sr);
    chk({tag, "_level"}, level, model.size());
    tick();
    chk({tag, "_ta_end"}, cmd_if.take_action, 0);
    chk({tag, "_tna_end"}, cmd_if.take_no_action, 0);
    chk({tag, "_jdo_hold"}, cmd_if.jdo, e.sr);
  endtask

  initial begin
    logic [SR_W-1:0] s;
    int              base;
    cmd_if.cmd_ready = 1'b0;

    // reset state
    #2;
    chk_all_zero("reset");
    tick(); tick();
    #2 reset_n = 1'b1;
    repeat (5) tick();
    chk_all_zero("post_reset");

    // push then pop with action decode, latency checked inside udr_event
    udr_event("push_act", 2'd2, rand_sr(1'b1), 1'b0, 1'b0);
    pop_check("pop_act");

    // no-action decode
    udr_event("push_noact", 2'd0, rand_sr(1'b0), 1'b0, 1'b0);
    pop_check("pop_noact");

    // randomized single push/pop pairs
    for (int i = 0; i < 6; i++) begin
      udr_event("rnd_push", IR_W'($urandom_range(0, 3)), rand_sr(1'($urandom)), 1'b0, 1'b0);
      pop_check("rnd_pop");
    end

    // ready while empty: nothing happens
    cmd_if.cmd_ready = 1'b1;
    repeat (3) begin
      tick();
      chk("empty_rdy_ta", cmd_if.take_action, 0);
      chk("empty_rdy_tna", cmd_if.take_no_action, 0);
      chk("empty_rdy_level", level, 0);
    end
    cmd_if.cmd_ready = 1'b0;

    // overflow: five captures into four entries, then drain in order
    for (int i = 0; i < 5; i++)
      udr_event("ovf_push", IR_W'($urandom_range(0, 3)), rand_sr(1'($urandom)), 1'b0, 1'b0);
    chk("ovf_level", level, 4);
    chk("ovf_flag", ovf_sticky, 1);
    for (int i = 0; i < 4; i++) pop_check("ovf_drain");
    chk("ovf_flag_kept", ovf_sticky, 1);

    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    ovf_model = 1'b0;
    chk("ovf_cleared", ovf_sticky, 0);

    // set wins over clear on the same edge
    for (int i = 0; i < 4; i++)
      udr_event("refill", IR_W'($urandom_range(0, 3)), rand_sr(1'($urandom)), 1'b0, 1'b0);
    udr_event("ovf_vs_clr", 2'd1, rand_sr(1'b1), 1'b0, 1'b1);
    chk("ovf_set_wins", ovf_sticky, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    ovf_model = 1'b0;
    chk("ovf_cleared2", ovf_sticky, 0);

    // full FIFO, push and pop on the same edge
    udr_event("full_pushpop", 2'd3, rand_sr(1'b0), 1'b1, 1'b0);
    chk("full_pushpop_level", level, 4);
    chk("full_pushpop_ovf", ovf_sticky, 0);
    for (int i = 0; i < 4; i++) pop_check("full_drain");

    // strobe held high for 20 cycles gives exactly one push, no ir_update
    base = uir_pulses;
    s = rand_sr(1'b1);
    ir_in = 2'd1; sr = s; vs_udr = 1'b1;
    repeat (20) tick();
    vs_udr = 1'b0;
    repeat (4) tick();
    model.push_back('{ir: 2'd1, sr: s});
    chk("hold_level", level, model.size());
    chk("hold_no_iru", uir_pulses - base, 0);
    pop_check("hold_pop");

    // vs_uir pulse: one ir_update after the 3rd edge, no push
    base = uir_pulses;
    vs_uir = 1'b1;
    tick(); tick();
    chk("iru_early", ir_update, 0);
    tick();
    chk("iru_pulse", ir_update, 1);
    vs_uir = 1'b0;
    tick();
    chk("iru_end", ir_update, 0);
    repeat (4) tick();
    chk("iru_count", uir_pulses - base, 1);
    chk("iru_no_push", level, 0);

    // asynchronous reset mid-operation with a pulse in flight
    for (int i = 0; i < 4; i++)
      udr_event("rst_fill", IR_W'($urandom_range(0, 3)), rand_sr(1'($urandom)), 1'b0, 1'b0);
    ir_in = 2'd2; sr = rand_sr(1'b1);
    vs_udr = 1'b1;
    cmd_if.cmd_ready = 1'b1;
    tick();
    cmd_if.cmd_ready = 1'b0;
    chk("rst_pre_level", level, 3);
    chk("rst_pulse_live", |(cmd_if.take_action | cmd_if.take_no_action), 1);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("rst_async");
    model.delete();
    ovf_model = 1'b0;
    tick();
    @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (6) begin
      tick();
      chk("rst_held_udr_valid", cmd_if.cmd_valid, 0);
      chk("rst_held_udr_level", level, 0);
    end
    vs_udr = 1'b0;
    repeat (3) tick();
    udr_event("rst_fresh", 2'd3, rand_sr(1'b1), 1'b0, 1'b0);
    pop_check("rst_fresh_pop");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
